beta_alu_pipe: RTL and testbench

Parametrised, handshaked successor to the Beta combinational ALU. It registers every result behind a valid/ready interface and adds a multi-cycle shift-add multiplier (MUL). It sits between operand fetch and write-back in the pipelined Beta datapath. It also fixes comparison semantics: compares are signed, computed from the Z/V/N flags of A−B.

---
 rtl/beta_alu_pipe.sv | 137 +++++++++++++
 tb/tb_beta_alu_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_alu_pipe.sv
// rtl/beta_alu_pipe.sv - registered Beta ALU with valid/ready handshake and shift-add MUL
// Single-cycle ops go straight to RC; MUL takes WIDTH iterations plus a write-back cycle.
module beta_alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [5:0]       FN,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RC,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   mul_count;

    logic             accept;
    logic             is_mul;
    logic             load_rc;
    logic [WIDTH-1:0] rc_next;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] alu_result;

    logic [WIDTH-1:0] diff;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic [3:0]       truth;
    logic [SHW-1:0]   sh;

    assign IN_READY = (state == ST_IDLE) && (!OUT_VALID || OUT_READY);
    assign accept   = IN_VALID && IN_READY;
    assign is_mul   = (FN[5:4] == 2'b00) && (FN[2:0] == 3'b001);

    // Signed compares derive from the flags of A-B rather than a direct magnitude test
    assign diff   = RA - RB;
    assign flag_z = (diff == '0);
    assign flag_n = diff[WIDTH-1];
    assign flag_v = (RA[WIDTH-1] != RB[WIDTH-1]) && (diff[WIDTH-1] != RA[WIDTH-1]);

    assign truth = FN[3:0];
    assign sh    = RB[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (FN[5:4])
            2'b00: begin
                case (FN[2:0])
                    3'b011:  alu_result = {{(WIDTH-1){1'b0}}, flag_z};
                    3'b101:  alu_result = {{(WIDTH-1){1'b0}}, flag_n ^ flag_v};
                    3'b111:  alu_result = {{(WIDTH-1){1'b0}}, flag_z | (flag_n ^ flag_v)};
                    default: alu_result = '0;
                endcase
            end
            2'b01: alu_result = FN[0] ? diff : (RA + RB);
            2'b10: begin
                for (int i = 0; i < WIDTH; i++) begin
                    alu_result[i] = truth[{RB[i], RA[i]}];
                end
            end
            default: begin
                case (FN[1:0])
                    2'b00:   alu_result = RA << sh;
                    2'b01:   alu_result = RA >> sh;
                    2'b11:   alu_result = $signed(RA) >>> sh;
                    default: alu_result = '0;
                endcase
            end
        endcase
    end

    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    assign load_rc = (state == ST_WB) || (accept && !is_mul);
    assign rc_next = (state == ST_WB) ? acc : alu_result;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            RC        <= '0;
            OUT_VALID <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_count <= '0;
        end else begin
            if (load_rc) begin
                RC        <= rc_next;
                OUT_VALID <= 1'b1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        mcand     <= RA;
                        mplier    <= RB;
                        acc       <= '0;
                        mul_count <= '0;
                        state     <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc       <= acc_step;
                    mcand     <= mcand << 1;
                    mplier    <= mplier >> 1;
                    mul_count <= mul_count + 1'b1;
                    if (mul_count == LAST_STEP) begin
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beta_alu_pipe.sv
// tb/tb_beta_alu_pipe.sv - directed scoreboard bench for beta_alu_pipe
module tb_beta_alu_pipe;

    localparam int W = 32;

    localparam logic [5:0] OP_ADD   = 6'b010000;
    localparam logic [5:0] OP_SUB   = 6'b010001;
    localparam logic [5:0] OP_AND   = 6'b101000;
    localparam logic [5:0] OP_OR    = 6'b101110;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_A     = 6'b101010;
    localparam logic [5:0] OP_SHL   = 6'b110000;
    localparam logic [5:0] OP_SHR   = 6'b110001;
    localparam logic [5:0] OP_SRA   = 6'b110011;
    localparam logic [5:0] OP_CMPEQ = 6'b000011;
    localparam logic [5:0] OP_CMPLT = 6'b000101;
    localparam logic [5:0] OP_CMPLE = 6'b000111;
    localparam logic [5:0] OP_MUL   = 6'b000001;
    localparam logic [5:0] OP_RSV0  = 6'b000000;
    localparam logic [5:0] OP_RSV3  = 6'b111010;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [5:0]   FN;
    logic [W-1:0] RA;
    logic [W-1:0] RB;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] RC;
    logic         OUT_VALID;
    logic         OUT_READY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int npop   = 0;
    logic [W-1:0] sb[$];

    beta_alu_pipe #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FN        (FN),
        .RA        (RA),
        .RB        (RB),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .RC        (RC),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [W-1:0] exp;
        if (!RESET && OUT_VALID && OUT_READY) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed RC=%h expected no output", RC);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                npop++;
                check("rc_scoreboard", RC, exp);
            end
        end
    endtask

    task automatic neg();
        @(negedge CLK);
        mon();
    endtask

    task automatic pos();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic issue_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, output int waited);
        FN = fn;
        RA = a;
        RB = b;
        IN_VALID = 1'b1;
        sb.push_back(exp);
        waited = 0;
        neg();
        while (!IN_READY && waited < 200) begin
            pos();
            neg();
            waited++;
        end
        checks++;
        assert (waited < 200) else begin
            errors++;
            $error("FAIL accept_timeout: observed %0d cycles expected < 200", waited);
        end
        pos();
        IN_VALID = 1'b0;
    endtask

    task automatic mul_test(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
        int w;
        int acc_c;
        int n;
        logic ready_seen;
        issue_op(OP_MUL, a, b, exp, w);
        acc_c = cyc;
        ready_seen = 1'b0;
        n = 0;
        while (n < 100) begin
            neg();
            if (OUT_VALID) break;
            ready_seen = ready_seen | IN_READY;
            pos();
            n++;
        end
        check("mul_latency", W'(cyc - acc_c), W'(W + 1));
        check("mul_in_ready_low", W'(ready_seen), '0);
        pos();
    endtask

    logic [5:0]   t_fn[9];
    logic [W-1:0] t_a[9];
    logic [W-1:0] t_b[9];
    logic [W-1:0] t_e[9];

    initial begin
        int w;
        int p0;
        logic seen;

        RESET = 1'b1;
        IN_VALID = 1'b0;
        FN = '0;
        RA = '0;
        RB = '0;
        OUT_READY = 1'b1;

        neg();
        check("reset_out_valid", W'(OUT_VALID), '0);
        check("reset_rc", RC, '0);
        pos();
        RESET = 1'b0;
        neg();
        check("post_reset_in_ready", W'(IN_READY), W'(1));
        pos();

        // back-to-back single-cycle ops at full rate
        p0 = npop;
        issue_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, w);
        check("b2b_ready0", W'(w), '0);
        issue_op(OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, w);
        check("b2b_ready1", W'(w), '0);
        issue_op(OP_AND, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, w);
        check("b2b_ready2", W'(w), '0);
        issue_op(OP_SRA, 32'h80000000, 32'h4, 32'hF8000000, w);
        check("b2b_ready3", W'(w), '0);
        issue_op(OP_SHL, 32'h1, 32'd31, 32'h80000000, w);
        check("b2b_ready4", W'(w), '0);
        neg();
        check("b2b_pops", W'(npop - p0), W'(5));
        pos();

        // signed compares and other encodings
        t_fn = '{OP_CMPLT, OP_CMPLT, OP_CMPLE, OP_CMPEQ, OP_OR, OP_XOR, OP_A, OP_SHR, OP_SHL};
        t_a  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd5, 32'h0F0F0F0F, 32'h0F0F0F0F,
                 32'h0F0F0F0F, 32'h80000000, 32'h1};
        t_b  = '{32'h1, 32'h80000000, 32'd5, 32'd6, 32'h00FF00FF, 32'h00FF00FF,
                 32'h00FF00FF, 32'h4, 32'h25};
        t_e  = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h0FFF0FFF, 32'h0FF00FF0,
                 32'h0F0F0F0F, 32'h08000000, 32'h20};
        for (int i = 0; i < 9; i++) begin
            issue_op(t_fn[i], t_a[i], t_b[i], t_e[i], w);
        end
        issue_op(OP_RSV0, 32'h12345678, 32'h9ABCDEF0, 32'h0, w);
        neg();
        pos();

        mul_test(32'h00010003, 32'h00000005, 32'h0005000F);
        mul_test(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // backpressure holds RC and blocks input
        OUT_READY = 1'b0;
        issue_op(OP_ADD, 32'd7, 32'd8, 32'd15, w);
        FN = OP_ADD;
        RA = 32'd2;
        RB = 32'd3;
        IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("bp_in_ready_low", W'(IN_READY), '0);
            check("bp_rc_hold", RC, 32'd15);
            pos();
        end
        sb.push_back(32'd5);
        OUT_READY = 1'b1;
        neg();
        check("bp_in_ready_release", W'(IN_READY), W'(1));
        pos();
        OUT_READY = 1'b0;
        IN_VALID = 1'b0;
        neg();
        check("bp_out_valid", W'(OUT_VALID), W'(1));
        check("bp_rc_new", RC, 32'd5);
        pos();
        OUT_READY = 1'b1;
        neg();
        pos();

        // asynchronous reset with a result pending
        OUT_READY = 1'b0;
        issue_op(OP_ADD, 32'd1, 32'd2, 32'd3, w);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_out_valid", W'(OUT_VALID), '0);
        check("async_rst_rc", RC, '0);
        sb.delete();
        pos();
        RESET = 1'b0;
        OUT_READY = 1'b1;
        neg();
        check("async_rst_in_ready", W'(IN_READY), W'(1));
        pos();

        // reset 10 cycles into a MUL discards it
        issue_op(OP_MUL, 32'd3, 32'd4, 32'd12, w);
        for (int i = 0; i < 10; i++) begin
            neg();
            pos();
        end
        RESET = 1'b1;
        sb.delete();
        pos();
        RESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            neg();
            seen = seen | OUT_VALID;
            pos();
        end
        check("mul_rst_no_output", W'(seen), '0);
        issue_op(OP_ADD, 32'd1, 32'd1, 32'd2, w);
        neg();
        check("post_mul_rst_valid", W'(OUT_VALID), W'(1));
        check("post_mul_rst_rc", RC, 32'd2);
        pos();

        issue_op(OP_RSV3, 32'hDEADBEEF, 32'h00000003, 32'h0, w);
        neg();
        check("rsv_out_valid", W'(OUT_VALID), W'(1));
        check("rsv_rc", RC, '0);
        pos();

        neg();
        check("scoreboard_empty", W'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
